vec_alu_sequencer: RTL and testbench

- Issue-side sequencer that drives the vector ALU datapath.
- Accepts one vector instruction per handshake and walks its elements one per cycle:
  - reads operands from the vector register file,
  - presents them with the opcode to the combinational ALU,
  - writes each ALU result back to the destination register.
- Sits between the instruction decode stage and the ALU/register-file pair.
- Is the only initiator of ALU operations.

---
 rtl/vec_alu_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_vec_alu_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_alu_sequencer.sv
// rtl/vec_alu_sequencer.sv - issue-side element sequencer for the vector ALU datapath
// Optional per-element write mask enabled by defining VEC_SEQ_MASK_EN.
module vec_alu_sequencer #(
    parameter int VLEN = 8,
    parameter int RW   = 3,
    localparam int IW  = $clog2(VLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [3:0]      instr_opcode,
    input  logic [RW-1:0]   instr_vd,
    input  logic [RW-1:0]   instr_va,
    input  logic [RW-1:0]   instr_vb,
    input  logic [7:0]      instr_scalar,
`ifdef VEC_SEQ_MASK_EN
    input  logic [VLEN-1:0] instr_mask,
`endif
    output logic            rf_rd_en,
    output logic [RW-1:0]   rf_rd_reg_a,
    output logic [RW-1:0]   rf_rd_reg_b,
    output logic [IW-1:0]   rf_rd_idx,
    input  logic [7:0]      rf_rd_data_a,
    input  logic [7:0]      rf_rd_data_b,
    output logic [3:0]      alu_opcode,
    output logic [7:0]      alu_val_a,
    output logic [7:0]      alu_val_b,
    input  logic [7:0]      alu_resultado,
    output logic            rf_wr_en,
    output logic [RW-1:0]   rf_wr_reg,
    output logic [IW-1:0]   rf_wr_idx,
    output logic [7:0]      rf_wr_data,
    output logic            busy,
    output logic            done,
    output logic            err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        DRAIN1 = 2'd2,
        DRAIN2 = 2'd3
    } state_t;

    state_t state_q, state_d;

    function automatic logic op_is_vv(input logic [3:0] op);
        return (op == 4'b0001) || (op == 4'b0010);
    endfunction

    function automatic logic op_is_vs(input logic [3:0] op);
        logic r;
        case (op)
            4'b0101, 4'b0110, 4'b0111, 4'b1000,
            4'b1001, 4'b1010, 4'b1011, 4'b1111: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    logic          accept;
    logic          legal;
    logic          finish;
    logic [IW-1:0] k_q;
    logic [RW-1:0] vd_q, va_q, vb_q;
    logic [7:0]    scalar_q;
    logic          vs_q;
    logic          s1_valid_q, s2_valid_q;
    logic [IW-1:0] s1_idx_q, s2_idx_q;
    logic          done_q, err_q;
    logic          wr_gate;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        legal   = op_is_vv(instr_opcode) || op_is_vs(instr_opcode);
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    accept = 1'b1;
                    if (legal) begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (k_q == IW'(VLEN - 1)) begin
                    state_d = DRAIN1;
                end
            end
            DRAIN1: state_d = DRAIN2;
            DRAIN2: begin
                state_d = IDLE;
                finish  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Fields are latched on every acceptance, illegal ones included, so
    // alu_opcode always reflects the most recently accepted instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opcode <= '0;
            vd_q       <= '0;
            va_q       <= '0;
            vb_q       <= '0;
            scalar_q   <= '0;
            vs_q       <= 1'b0;
        end else if (accept) begin
            alu_opcode <= instr_opcode;
            vd_q       <= instr_vd;
            va_q       <= instr_va;
            vb_q       <= instr_vb;
            scalar_q   <= instr_scalar;
            vs_q       <= op_is_vs(instr_opcode);
        end
    end

    // Element counter wraps to zero after the last read since VLEN is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q <= '0;
        end else if (state_q == READ) begin
            k_q <= k_q + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_idx_q   <= '0;
            alu_val_a  <= '0;
            alu_val_b  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            s1_valid_q <= (state_q == READ);
            s1_idx_q   <= k_q;
            s2_valid_q <= s1_valid_q;
            s2_idx_q   <= s1_idx_q;
            if (s1_valid_q) begin
                alu_val_a <= rf_rd_data_a;
                alu_val_b <= vs_q ? scalar_q : rf_rd_data_b;
            end
            done_q <= finish || (accept && !legal);
            err_q  <= accept && !legal;
        end
    end

`ifdef VEC_SEQ_MASK_EN
    logic [VLEN-1:0] mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else if (accept) begin
            mask_q <= instr_mask;
        end
    end

    assign wr_gate = mask_q[s2_idx_q];
`else
    assign wr_gate = 1'b1;
`endif

    assign instr_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign rf_rd_en    = (state_q == READ);
    assign rf_rd_idx   = k_q;
    assign rf_rd_reg_a = va_q;
    assign rf_rd_reg_b = vb_q;
    assign rf_wr_en    = s2_valid_q && wr_gate;
    assign rf_wr_reg   = vd_q;
    assign rf_wr_idx   = s2_idx_q;
    assign rf_wr_data  = s2_valid_q ? alu_resultado : 8'h00;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// tb/tb_vec_alu_sequencer.sv - randomized self-checking bench for vec_alu_sequencer
module tb_vec_alu_sequencer;
    localparam int VLEN = 8;
    localparam int RW   = 3;
    localparam int IW   = $clog2(VLEN);
    localparam int NREG = 1 << RW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            instr_valid = 1'b0;
    logic            instr_ready;
    logic [3:0]      instr_opcode = '0;
    logic [RW-1:0]   instr_vd = '0, instr_va = '0, instr_vb = '0;
    logic [7:0]      instr_scalar = '0;
    logic [VLEN-1:0] instr_mask = '1;
    logic            rf_rd_en;
    logic [RW-1:0]   rf_rd_reg_a, rf_rd_reg_b;
    logic [IW-1:0]   rf_rd_idx;
    logic [7:0]      rf_rd_data_a = '0, rf_rd_data_b = '0;
    logic [3:0]      alu_opcode;
    logic [7:0]      alu_val_a, alu_val_b;
    logic [7:0]      alu_resultado;
    logic            rf_wr_en;
    logic [RW-1:0]   rf_wr_reg;
    logic [IW-1:0]   rf_wr_idx;
    logic [7:0]      rf_wr_data;
    logic            busy, done, err;

    vec_alu_sequencer #(.VLEN(VLEN), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_opcode(instr_opcode), .instr_vd(instr_vd), .instr_va(instr_va),
        .instr_vb(instr_vb), .instr_scalar(instr_scalar),
`ifdef VEC_SEQ_MASK_EN
        .instr_mask(instr_mask),
`endif
        .rf_rd_en(rf_rd_en), .rf_rd_reg_a(rf_rd_reg_a), .rf_rd_reg_b(rf_rd_reg_b),
        .rf_rd_idx(rf_rd_idx), .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b),
        .alu_opcode(alu_opcode), .alu_val_a(alu_val_a), .alu_val_b(alu_val_b),
        .alu_resultado(alu_resultado),
        .rf_wr_en(rf_wr_en), .rf_wr_reg(rf_wr_reg), .rf_wr_idx(rf_wr_idx),
        .rf_wr_data(rf_wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'b0001, 4'b0101: return a + b;
            4'b0010, 4'b0110, 4'b1011: return a - b;
            4'b0111: return a & b;
            4'b1000: return a | b;
            4'b1001: return a ^ b;
            4'b1010: return a << b[2:0];
            4'b1111: return b - a;
            default: return 8'hA5;
        endcase
    endfunction

    function automatic bit is_vs(input logic [3:0] op);
        return op inside {4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1111};
    endfunction

    function automatic bit is_legal(input logic [3:0] op);
        return is_vs(op) || op == 4'b0001 || op == 4'b0010;
    endfunction

    // Register file and ALU behaviour seen by the DUT
    logic [7:0] rf [NREG][VLEN];
    logic [7:0] ref_rf [NREG][VLEN];

    assign alu_resultado = alu_fn(alu_opcode, alu_val_a, alu_val_b);

    always @(posedge clk) begin
        if (rf_rd_en) begin
            rf_rd_data_a <= rf[rf_rd_reg_a][rf_rd_idx];
            rf_rd_data_b <= rf[rf_rd_reg_b][rf_rd_idx];
        end
        if (rf_wr_en) rf[rf_wr_reg][rf_wr_idx] <= rf_wr_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int wq_cyc[$], wq_reg[$], wq_idx[$], wq_data[$], wq_valb[$];
    int rd_cnt, done_cyc, err_cyc;
    int last_acc;

    always @(negedge clk) begin
        if (rf_wr_en) begin
            wq_cyc.push_back(cyc);
            wq_reg.push_back(int'(rf_wr_reg));
            wq_idx.push_back(int'(rf_wr_idx));
            wq_data.push_back(int'(rf_wr_data));
            wq_valb.push_back(int'(alu_val_b));
        end
        if (rf_rd_en) rd_cnt++;
        if (done && done_cyc < 0) done_cyc = cyc;
        if (err && err_cyc < 0) err_cyc = cyc;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        wq_cyc.delete(); wq_reg.delete(); wq_idx.delete(); wq_data.delete(); wq_valb.delete();
        rd_cnt = 0; done_cyc = -1; err_cyc = -1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [RW-1:0] d, a, b,
                         input logic [7:0] s, input logic [VLEN-1:0] m);
        instr_opcode = op; instr_vd = d; instr_va = a; instr_vb = b;
        instr_scalar = s; instr_mask = m;
    endtask

    // Called between a posedge and the following posedge; returns just after the acceptance edge.
    task automatic issue(input logic [3:0] op, input logic [RW-1:0] d, a, b,
                         input logic [7:0] s, input logic [VLEN-1:0] m);
        drive(op, d, a, b, s, m);
        instr_valid = 1'b1;
        for (int i = 0; i < 40 && !instr_ready; i++) begin
            @(negedge clk); #1;
        end
        check("ready_before_issue", instr_ready, 1'b1);
        last_acc = cyc;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        clear_logs();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && done_cyc < 0; i++) begin
            @(negedge clk); #1;
        end
        if (done_cyc < 0) check("done_timeout", 0, 1);
    endtask

    task automatic cmp_rf(input string tag);
        logic [63:0] g, e;
        for (int r = 0; r < NREG; r++) begin
            g = '0; e = '0;
            for (int k = 0; k < VLEN; k++) begin
                g[k*8 +: 8] = rf[r][k];
                e[k*8 +: 8] = ref_rf[r][k];
            end
            check($sformatf("%s_reg%0d", tag, r), g, e);
        end
    endtask

    task automatic model_apply(input logic [3:0] op, input logic [RW-1:0] d, a, b,
                               input logic [7:0] s, input logic [VLEN-1:0] m, input int upto);
        logic [7:0] sa [VLEN];
        logic [7:0] sb [VLEN];
        for (int k = 0; k < VLEN; k++) begin
            sa[k] = ref_rf[a][k];
            sb[k] = ref_rf[b][k];
        end
        if (is_legal(op))
            for (int k = 0; k < upto; k++)
                if (m[k]) ref_rf[d][k] = alu_fn(op, sa[k], is_vs(op) ? s : sb[k]);
    endtask

    task automatic run_instr(input string tag, input logic [3:0] op, input logic [RW-1:0] d, a, b,
                             input logic [7:0] s, input logic [VLEN-1:0] m);
        logic [7:0] exp_data [VLEN];
        int j;
        for (int k = 0; k < VLEN; k++)
            exp_data[k] = alu_fn(op, ref_rf[a][k], is_vs(op) ? s : ref_rf[b][k]);
        issue(op, d, a, b, s, m);
        wait_done();
        if (is_legal(op)) begin
            check({tag, "_nwr"}, wq_cyc.size(), $countones(m));
            j = 0;
            for (int k = 0; k < VLEN; k++) begin
                if (m[k] && j < wq_cyc.size()) begin
                    check({tag, "_wr_meta"}, {wq_cyc[j] - last_acc, wq_reg[j], wq_idx[j]},
                          {3 + k, int'(d), k});
                    check({tag, "_wr_data"}, wq_data[j], exp_data[k]);
                    if (is_vs(op)) check({tag, "_valb"}, wq_valb[j], s);
                    j++;
                end
            end
            check({tag, "_nrd"}, rd_cnt, VLEN);
            check({tag, "_done_cyc"}, done_cyc - last_acc, VLEN + 3);
            check({tag, "_no_err"}, err_cyc, -1);
        end else begin
            check({tag, "_nwr"}, wq_cyc.size(), 0);
            check({tag, "_nrd"}, rd_cnt, 0);
            check({tag, "_done_cyc"}, done_cyc - last_acc, 1);
            check({tag, "_err_cyc"}, err_cyc - last_acc, 1);
            check({tag, "_ready"}, instr_ready, 1'b1);
        end
        model_apply(op, d, a, b, s, m, VLEN);
        cmp_rf(tag);
    endtask

    function automatic logic [VLEN-1:0] rand_mask();
`ifdef VEC_SEQ_MASK_EN
        return VLEN'($urandom);
`else
        return '1;
`endif
    endfunction

    initial begin
        int prev;
        logic [3:0] op;
        clear_logs();
        for (int r = 0; r < NREG; r++)
            for (int k = 0; k < VLEN; k++) begin
                rf[r][k] = 8'($urandom);
                ref_rf[r][k] = rf[r][k];
            end
        for (int k = 0; k < VLEN; k++) begin
            rf[1][k] = 8'(10 + k); ref_rf[1][k] = 8'(10 + k);
            rf[2][k] = 8'd5;       ref_rf[2][k] = 8'd5;
            rf[4][k] = 8'h20;      ref_rf[4][k] = 8'h20;
        end

        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", instr_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_rd_en", rf_rd_en, 1'b0);
        check("rst_wr_en", rf_wr_en, 1'b0);
        check("rst_wr_data", rf_wr_data, 8'h00);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("idle_ready", instr_ready, 1'b1);
        check("idle_busy", busy, 1'b0);

        run_instr("vv_add", 4'b0001, 3'd3, 3'd1, 3'd2, 8'h00, '1);
        for (int k = 0; k < VLEN; k++) check("vv_add_abs", rf[3][k], 8'(15 + k));

        run_instr("vs_inplace", 4'b1011, 3'd4, 3'd4, 3'd6, 8'h01, '1);
        for (int k = 0; k < VLEN; k++) check("vs_inplace_abs", rf[4][k], 8'h1F);

        run_instr("illegal", 4'b0011, 3'd5, 3'd1, 3'd2, 8'h00, '1);
        prev = last_acc;
        run_instr("after_ill", 4'b0010, 3'd5, 3'd1, 3'd2, 8'h00, '1);
        check("ill_next_acc", last_acc - prev, 1);

        // Back-to-back with instr_valid held high
        begin
            int acc1;
            drive(4'b0001, 3'd6, 3'd1, 3'd2, 8'h00, '1);
            instr_valid = 1'b1;
            acc1 = cyc;
            @(posedge clk); #1;
            drive(4'b0101, 3'd7, 3'd6, 3'd0, 8'h03, '1);
            for (int i = 0; i < 30; i++) begin
                @(negedge clk); #1;
                if (instr_ready) break;
            end
            check("b2b_acc_cyc", cyc - acc1, VLEN + 3);
            @(posedge clk); #1;
            instr_valid = 1'b0;
            clear_logs();
            @(negedge clk); #1;
            check("b2b_first_rd", {rf_rd_en, rf_rd_idx, 32'(cyc - acc1)}, {1'b1, IW'(0), 32'(VLEN + 4)});
            wait_done();
            model_apply(4'b0001, 3'd6, 3'd1, 3'd2, 8'h00, '1, VLEN);
            model_apply(4'b0101, 3'd7, 3'd6, 3'd0, 8'h03, '1, VLEN);
            cmp_rf("b2b");
        end

        // Reset in cycle 5 of an active 0010: elements 0 and 1 already written
        issue(4'b0010, 3'd0, 3'd1, 3'd2, 8'h00, '1);
        model_apply(4'b0010, 3'd0, 3'd1, 3'd2, 8'h00, '1, 2);
        while (cyc < last_acc + 5) begin
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", instr_ready, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_rd_en", rf_rd_en, 1'b0);
        check("mid_rst_wr_en", rf_wr_en, 1'b0);
        check("mid_rst_alu", {alu_opcode, alu_val_a, alu_val_b}, 20'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        clear_logs();
        repeat (15) @(negedge clk);
        #1;
        check("post_rst_nwr", wq_cyc.size(), 0);
        check("post_rst_done", done_cyc, -1);
        cmp_rf("post_rst");
        run_instr("after_rst", 4'b1001, 3'd2, 3'd0, 3'd3, 8'h5A, '1);

`ifdef VEC_SEQ_MASK_EN
        run_instr("mask", 4'b0001, 3'd5, 3'd1, 3'd2, 8'h00, 8'b10100101);
`endif

        for (int t = 0; t < 12; t++) begin
            op = 4'($urandom_range(0, 15));
            run_instr($sformatf("rnd%0d", t), op, RW'($urandom), RW'($urandom), RW'($urandom),
                      8'($urandom), rand_mask());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
